tag_wakeup_queue: RTL and testbench
===================================

Name: tag_wakeup_queue

Overview:
- Issue-queue slot array that consumes 10-bit tag-equality results: each entry holds two source tags, and each tag is compared against the common-data-bus (CDB) broadcast tag every cycle.
- An entry becomes issuable when both sources are ready; the lowest-index ready entry is presented downstream.
- Sits between rename/dispatch (upstream) and the execute units (downstream).

Parameters:
DEPTH, 8, number of entries (power of two, 2..16)
TAG_W, 10, physical register tag width
PAYLOAD_W, 32, opaque per-entry payload (opcode/immediate) carried to issue

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  clear all entries at next edge
in_valid  input  1  dispatch request
in_ready  output  1  queue can accept an entry this cycle
in_src1_tag  input  TAG_W  source 1 tag
in_src1_rdy  input  1  source 1 already available
in_src2_tag  input  TAG_W  source 2 tag
in_src2_rdy  input  1  source 2 already available
in_dst_tag  input  TAG_W  destination tag, passed through to issue
in_payload  input  PAYLOAD_W  passed through to issue
cdb_valid  input  1  broadcast tag valid
cdb_tag  input  TAG_W  broadcast (completing) tag
out_valid  output  1  an entry is issuable
out_ready  input  1  execute unit accepts
out_dst_tag  output  TAG_W  dst tag of selected entry
out_payload  output  PAYLOAD_W  payload of selected entry
count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Per-entry state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, dst_tag, payload.
- Reset: all valid=0 and count=0. Outputs after reset: in_ready=1, out_valid=0, out_dst_tag=0, out_payload=0.
- Accept:
  - Handshake completes when in_valid && in_ready.
  - The entry is written into the lowest-index free slot at the edge and becomes visible the next cycle.
  - in_ready = (count < DEPTH). It depends only on registered state, so a same-cycle issue does not free space for that cycle's accept.
- Wakeup:
  - For every valid entry, a source sets rdy=1 at the edge when cdb_valid && (src_tag == cdb_tag).
  - Tags compare on the full TAG_W width. A rdy bit, once set, stays set until the entry is freed.
- Select:
  - out_valid = OR over entries of (valid && src1_rdy && src2_rdy).
  - The selected entry is the lowest-index such entry. out_dst_tag/out_payload come from that entry, are driven from registered state only, and are 0 when out_valid=0.
  - Issue latency is 1 cycle after the wakeup edge at the earliest: a CDB match in cycle N makes the entry issuable in N+1.
- Issue: on out_valid && out_ready, the selected entry's valid bit is cleared at the edge. out_valid may drop or change entry in the next cycle. out_ready with out_valid=0 has no effect.
- Simultaneous accept and issue in one cycle: both take effect and count is unchanged. The accepted entry may reuse the just-freed slot only from the following cycle.
- Simultaneous CDB match and issue of the same entry: the issue wins and the entry is freed.
- Full (count==DEPTH): in_ready=0; in_valid is ignored with no state change. Empty: out_valid=0.
- Flush: at the edge, all valid bits clear and count becomes 0. Flush overrides accept, issue and wakeup in that cycle. Reset overrides flush.
- Reset mid-operation: all entries are discarded at the edge regardless of any handshake in progress.
- count = number of valid bits; it never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: TAG_WAKEUP_BYPASS_EN.
- Defined: an accepted entry whose in_srcN_tag matches cdb_tag while cdb_valid=1 in the accept cycle is written with srcN_rdy=1. Such an entry is issuable the next cycle. in_ready = (count < DEPTH).
- Undefined: no compare on the write path. To avoid a missed wakeup, in_ready = (count < DEPTH) && !cdb_valid, so dispatch stalls in any cycle with a broadcast.

Test Plan:
- Reset, then idle 3 cycles -> in_ready=1, out_valid=0, count=0, out_dst_tag=0.
- Accept {src1=0x005 rdy=1, src2=0x3FF rdy=0, dst=0x010}; cdb 0x3FE in the next cycle -> no issue. cdb 0x3FF in the following cycle -> out_valid=1 with out_dst_tag=0x010 one cycle later; out_ready=1 -> count returns to 0.
- Fill 8 entries, all sources ready -> count=8, in_ready=0. Hold out_ready=1 -> issue order is slots 0..7, one per cycle. A same-cycle accept is held off until count<8.
- Entries in slots 2 and 5 both wait on tag 0x123; broadcast 0x123 once -> both wake, slot 2 issues first, then slot 5.
- Full queue with flush=1 alongside in_valid=1, out_ready=1 and a matching cdb -> next cycle count=0, out_valid=0.
- Accept {src1=0x044 rdy=0, src2 rdy=1} in the same cycle as cdb 0x044. With TAG_WAKEUP_BYPASS_EN: out_valid=1 the next cycle. Without it: in_ready=0 that cycle and no entry is written.

Source files
------------

// File: rtl/tag_wakeup_queue.sv
// Issue-queue slot array: CDB tag wakeup, lowest-index select, in-order slot allocation.
// Optional macro TAG_WAKEUP_BYPASS_EN: CDB compare on the dispatch write path.
module tag_wakeup_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TAG_W-1:0]             in_src1_tag,
  input  logic                         in_src1_rdy,
  input  logic [TAG_W-1:0]             in_src2_tag,
  input  logic                         in_src2_rdy,
  input  logic [TAG_W-1:0]             in_dst_tag,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAG_W-1:0]             out_dst_tag,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     vld;
  logic [DEPTH-1:0]     s1_rdy;
  logic [DEPTH-1:0]     s2_rdy;
  logic [TAG_W-1:0]     s1_tag [DEPTH];
  logic [TAG_W-1:0]     s2_tag [DEPTH];
  logic [TAG_W-1:0]     dst    [DEPTH];
  logic [PAYLOAD_W-1:0] pay    [DEPTH];
  logic [CNT_W-1:0]     cnt;

  logic [DEPTH-1:0] issuable;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             acc;
  logic             iss;
  logic             wr_s1_rdy;
  logic             wr_s2_rdy;

  // Lowest free slot and lowest issuable slot (scan high-to-low so the lowest wins)
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    issuable = vld & s1_rdy & s2_rdy;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!vld[i])     free_idx = IDX_W'(i);
      if (issuable[i]) sel_idx  = IDX_W'(i);
    end
  end

`ifdef TAG_WAKEUP_BYPASS_EN
  assign in_ready  = (cnt < CNT_W'(DEPTH));
  assign wr_s1_rdy = in_src1_rdy | (cdb_valid && (in_src1_tag == cdb_tag));
  assign wr_s2_rdy = in_src2_rdy | (cdb_valid && (in_src2_tag == cdb_tag));
`else
  // Without a write-path compare, a broadcast during dispatch would be missed
  assign in_ready  = (cnt < CNT_W'(DEPTH)) && !cdb_valid;
  assign wr_s1_rdy = in_src1_rdy;
  assign wr_s2_rdy = in_src2_rdy;
`endif

  assign acc         = in_valid && in_ready;
  assign out_valid   = |issuable;
  assign iss         = out_valid && out_ready;
  assign out_dst_tag = out_valid ? dst[sel_idx] : '0;
  assign out_payload = out_valid ? pay[sel_idx] : '0;
  assign count       = cnt;

  // Occupancy: accept and issue can never target the same slot in one cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      if (iss) vld[sel_idx]  <= 1'b0;
      if (acc) vld[free_idx] <= 1'b1;
      cnt <= cnt + CNT_W'(acc) - CNT_W'(iss);
    end
  end

  // Entry contents; only meaningful while the matching vld bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld[i] && cdb_valid && (s1_tag[i] == cdb_tag)) s1_rdy[i] <= 1'b1;
      if (vld[i] && cdb_valid && (s2_tag[i] == cdb_tag)) s2_rdy[i] <= 1'b1;
    end
    if (acc) begin
      s1_tag[free_idx] <= in_src1_tag;
      s2_tag[free_idx] <= in_src2_tag;
      s1_rdy[free_idx] <= wr_s1_rdy;
      s2_rdy[free_idx] <= wr_s2_rdy;
      dst[free_idx]    <= in_dst_tag;
      pay[free_idx]    <= in_payload;
    end
  end

endmodule

// File: tb/tb_tag_wakeup_queue.sv
// Scoreboard bench for tag_wakeup_queue: directed dispatch/wakeup/flush scenarios.
module tb_tag_wakeup_queue;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned TAG_W     = 10;
  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 reset, flush, in_valid, in_ready;
  logic [TAG_W-1:0]     in_src1_tag, in_src2_tag, in_dst_tag, cdb_tag, out_dst_tag;
  logic                 in_src1_rdy, in_src2_rdy, cdb_valid, out_valid, out_ready;
  logic [PAYLOAD_W-1:0] in_payload, out_payload;
  logic [CNT_W-1:0]     count;

  logic [TAG_W+PAYLOAD_W-1:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  tag_wakeup_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
    .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy),
    .in_dst_tag(in_dst_tag), .in_payload(in_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dst_tag(out_dst_tag), .out_payload(out_payload),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [TAG_W-1:0] d, input logic [PAYLOAD_W-1:0] p);
    sb.push_back({d, p});
  endtask

  task automatic drive(input logic [TAG_W-1:0] s1, input logic r1,
                       input logic [TAG_W-1:0] s2, input logic r2,
                       input logic [TAG_W-1:0] d, input logic [PAYLOAD_W-1:0] p);
    in_valid    = 1'b1;
    in_src1_tag = s1;
    in_src1_rdy = r1;
    in_src2_tag = s2;
    in_src2_rdy = r2;
    in_dst_tag  = d;
    in_payload  = p;
  endtask

  // Monitor: every completed issue handshake must match the scoreboard head
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", {out_dst_tag, out_payload}, 64'hDEAD);
      end else begin
        chk("issue", {out_dst_tag, out_payload}, sb.pop_front());
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_src1_tag = '0; in_src1_rdy = 1'b0; in_src2_tag = '0; in_src2_rdy = 1'b0;
    in_dst_tag = '0; in_payload = '0; cdb_valid = 1'b0; cdb_tag = '0;
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_dst", 64'(out_dst_tag), 64'd0);
    chk("rst_out_payload", 64'(out_payload), 64'd0);

    // Single entry waits on 0x3FF; a near-miss tag must not wake it
    drive(10'h005, 1'b1, 10'h3FF, 1'b0, 10'h010, 32'hA0);
    tick();
    in_valid = 1'b0;
    chk("one_count", 64'(count), 64'd1);
    chk("one_not_ready", 64'(out_valid), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 10'h3FE;
    tick();
    chk("near_miss", 64'(out_valid), 64'd0);
    cdb_tag = 10'h3FF;
    tick();
    cdb_valid = 1'b0;
    chk("wake_valid", 64'(out_valid), 64'd1);
    chk("wake_dst", 64'(out_dst_tag), 64'h010);
    push_exp(10'h010, 32'hA0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_drained", 64'(count), 64'd0);

    // Fill all slots with ready entries
    for (int i = 0; i < 8; i++) begin
      drive(10'h001, 1'b1, 10'h002, 1'b1, 10'(10'h100 + i), 32'(i));
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    // Accept held off while full; freed slot 0 reused one cycle later
    push_exp(10'h100, 32'd0);
    push_exp(10'h101, 32'd1);
    drive(10'h001, 1'b1, 10'h002, 1'b1, 10'h1AA, 32'hAA);
    out_ready = 1'b1;
    tick();
    chk("held_count", 64'(count), 64'd7);
    chk("held_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("acc_iss_count", 64'(count), 64'd7);
    push_exp(10'h1AA, 32'hAA);
    for (int i = 2; i < 8; i++) push_exp(10'(10'h100 + i), 32'(i));
    repeat (7) tick();
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Slots 2 and 5 share a wakeup tag; others wait on 0x200
    for (int i = 0; i < 6; i++) begin
      if (i == 2 || i == 5) drive(10'h001, 1'b1, 10'h123, 1'b0, 10'(10'h020 + i), 32'(32'h50 + i));
      else                  drive(10'h200, 1'b0, 10'h002, 1'b1, 10'(10'h020 + i), 32'(32'h50 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("pair_idle", 64'(out_valid), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 10'h123;
    tick();
    cdb_valid = 1'b0;
    chk("pair_valid", 64'(out_valid), 64'd1);
    chk("pair_first", 64'(out_dst_tag), 64'h022);
    push_exp(10'h022, 32'h52);
    push_exp(10'h025, 32'h55);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk("pair_count", 64'(count), 64'd4);
    chk("pair_rest_idle", 64'(out_valid), 64'd0);

    // Refill to full, then flush against accept, issue and wakeup
    for (int i = 0; i < 4; i++) begin
      drive(10'h001, 1'b1, 10'h002, 1'b1, 10'(10'h060 + i), 32'(i));
      tick();
    end
    chk("flush_pre_count", 64'(count), 64'd8);
    flush = 1'b1; out_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 10'h200;
    tick();
    flush = 1'b0; out_ready = 1'b0; cdb_valid = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);

    // Dispatch in the same cycle as the broadcast of its source tag
    drive(10'h044, 1'b0, 10'h002, 1'b1, 10'h0C4, 32'hC4);
    cdb_valid = 1'b1; cdb_tag = 10'h044;
`ifdef TAG_WAKEUP_BYPASS_EN
    chk("bypass_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; cdb_valid = 1'b0;
    chk("bypass_valid", 64'(out_valid), 64'd1);
    push_exp(10'h0C4, 32'hC4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bypass_drained", 64'(count), 64'd0);
`else
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0; cdb_valid = 1'b0;
    chk("stall_count", 64'(count), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd0);
`endif

    // Reset mid-operation discards a pending entry
    drive(10'h001, 1'b1, 10'h002, 1'b1, 10'h077, 32'h77);
    tick();
    chk("pre_reset_count", 64'(count), 64'd1);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("mid_reset_count", 64'(count), 64'd0);
    chk("mid_reset_out_valid", 64'(out_valid), 64'd0);

    tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
